dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between the pipeline MEM stage (CPU requester) and a DMA/debug requester.
- Owns the memory command interface and sequences each access through a fixed-latency read path.
- Drives StallM to freeze the MEM pipeline register until the CPU access completes.
- Sits between the MEM-stage pipeline register outputs and the data memory macro.

Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged).
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range is 1 or more.
- STARVE_LIMIT, 4, number of CPU wins over a pending DMA request before DMA is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- MemReadM  in  1  CPU load request.
- MemWriteM  in  1  CPU store request.
- ALUResultM  in  ADDR_W  CPU address.
- WriteDataM  in  DATA_W  CPU store data.
- ReadDataM  out  DATA_W  CPU load data.
- StallM  out  1  freeze IF..MEM pipeline registers.
- dma_req  in  1  DMA request; dma_we, dma_addr and dma_wdata must be stable while high.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  one-cycle pulse: DMA command captured.
- dma_done  out  1  one-cycle completion pulse.
- dma_rdata  out  DATA_W  DMA read data, valid with dma_done.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, async): state=IDLE, owner=CPU, starve_cnt=0. All registered outputs are 0: mem_*, ReadDataM, dma_rdata, dma_gnt, dma_done. StallM follows its equation.
- Reset mid-access aborts the access immediately: mem_en drops, no dma_done is issued, and the access is not retried.
- CPU request: cpu_req = MemReadM | MemWriteM. If both are high, the access is treated as a write.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration:
  - CPU wins if cpu_req and not (dma_req and starve_cnt>=STARVE_LIMIT).
  - Otherwise DMA wins if dma_req.
  - Otherwise stay in IDLE.
  - The winner's command (we/addr/wdata) is latched at the clock edge; next state is ISSUE.
  - dma_gnt=1 in the IDLE cycle in which DMA wins. DMA may change its inputs after that cycle.
- starve_cnt:
  - +1 (saturating) on each IDLE arbitration where both requested and CPU won.
  - Cleared to 0 on a DMA win.
- ISSUE (1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata come from the latched command. Next state: write -> DONE; read -> WAIT with cnt=MEM_LAT-1.
- WAIT:
  - mem_en=0. cnt decrements each cycle.
  - When cnt==0, mem_rdata is captured (exactly MEM_LAT cycles after ISSUE) into ReadDataM (owner CPU) or dma_rdata (owner DMA), then the FSM goes to DONE.
- DONE (1 cycle):
  - If owner is DMA, dma_done=1.
  - Next state is always IDLE, so back-to-back accesses have a one-cycle IDLE gap.
- StallM (combinational) = cpu_req & ~(state==DONE & owner==CPU).
  - CPU read latency with no contention: stall for MEM_LAT+2 cycles, released in DONE.
  - CPU write: stall for 2 cycles.
- ReadDataM holds its value until the next CPU read capture. dma_rdata holds its value until the next DMA read capture.
- If dma_req is still high in IDLE after a dma_done, it is treated as a new request.
- CPU inputs are stable while StallM=1 because the pipeline is frozen. In DONE the pipeline advances.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3), owner encoding (CPU=0, DMA=1), and default MEM_LAT/STARVE_LIMIT constants.
- One sub-module, dmem_arb_sel: holds the starve_cnt register and the winner/starvation pick logic. The top level contains the FSM, latency counter, command latch and read-data capture.

Test Plan:
- Reset, then CPU load (MemReadM=1, ALUResultM=0x1000) with mem_rdata=0xDEADBEEF at ISSUE+2:
  - mem_en pulses exactly once.
  - StallM is high for 4 cycles, low in DONE.
  - ReadDataM=0xDEADBEEF.
- CPU store (MemWriteM=1, addr 0x1010, data 0x00000020):
  - mem_en=mem_we=1 for one cycle with that addr/data.
  - StallM is high for 2 cycles.
  - No dma_done.
- DMA read alone (dma_req=1, dma_addr=0x2000, mem_rdata=0x12345678):
  - dma_gnt pulses in IDLE, then dma_done after MEM_LAT+2 cycles.
  - dma_rdata=0x12345678.
  - StallM stays 0.
- CPU and DMA both requesting continuously, STARVE_LIMIT=4: grant sequence is CPU,CPU,CPU,CPU,DMA,CPU…, and starve_cnt returns to 0 after the DMA grant.
- Assert reset=0 during WAIT of a DMA read:
  - All outputs go to 0 immediately.
  - No dma_done.
  - FSM is in IDLE after reset release.
- MemReadM and MemWriteM both set: mem_we=1 (treated as write), and the stall length matches a write (2 cycles).

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types: FSM state and access-owner encodings,
// plus default widths, memory latency and starvation limit.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_MEM_LAT      = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter bus: CPU MEM-stage port, DMA port and memory command port.
// master = arbiter view, slave = pipeline/DMA/memory environment view.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              MemReadM;
  logic              MemWriteM;
  logic [ADDR_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ReadDataM;
  logic              StallM;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  MemReadM, MemWriteM,
    input  ALUResultM, WriteDataM,
    output ReadDataM, StallM,
    input  dma_req, dma_we,
    input  dma_addr, dma_wdata,
    output dma_gnt, dma_done,
    output dma_rdata,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output MemReadM, MemWriteM,
    output ALUResultM, WriteDataM,
    input  ReadDataM, StallM,
    output dma_req, dma_we,
    output dma_addr, dma_wdata,
    input  dma_gnt, dma_done,
    input  dma_rdata,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_sel.sv
// Winner pick for the IDLE arbitration slot with DMA anti-starvation.
// Ports: arb_en (FSM idle), cpu_req/dma_req in; cpu_win/dma_win out.
module dmem_arb_sel
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic dma_req,
  output logic cpu_win,
  output logic dma_win
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          starved;

  always_comb begin
    starved      = dma_req && (starve_cnt_q >= LIM);
    cpu_win      = arb_en && cpu_req && !starved;
    dma_win      = arb_en && dma_req && !cpu_win;
    starve_cnt_d = starve_cnt_q;
    if (dma_win) begin
      starve_cnt_d = '0;
    end else if (cpu_win && dma_req
                 && starve_cnt_q < LIM) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage vs DMA, fixed-latency read path.
// Ports: clk, reset (async, active-low), bus (dmem_arbiter_if.master).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MEM_LAT      = DEF_MEM_LAT,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.master bus
);

  localparam int unsigned CNT_W =
    (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] dma_rd_q, dma_rd_d;

  logic cpu_req;
  logic cpu_win;
  logic dma_win;
  logic issue;

  assign cpu_req = bus.MemReadM | bus.MemWriteM;

  dmem_arb_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk    (clk),
    .reset  (reset),
    .arb_en (state_q == S_IDLE),
    .cpu_req(cpu_req),
    .dma_req(bus.dma_req),
    .cpu_win(cpu_win),
    .dma_win(dma_win)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    cpu_rd_d = cpu_rd_q;
    dma_rd_d = dma_rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_win) begin
          owner_d = OWN_CPU;
          // read+write together is a store
          we_d    = bus.MemWriteM;
          addr_d  = bus.ALUResultM;
          wdata_d = bus.WriteDataM;
          state_d = S_ISSUE;
        end else if (dma_win) begin
          owner_d = OWN_DMA;
          we_d    = bus.dma_we;
          addr_d  = bus.dma_addr;
          wdata_d = bus.dma_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_CPU)
            cpu_rd_d = bus.mem_rdata;
          else
            dma_rd_d = bus.mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      cpu_rd_q <= cpu_rd_d;
      dma_rd_q <= dma_rd_d;
    end
  end

  assign issue         = (state_q == S_ISSUE);
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue & we_q;
  assign bus.mem_addr  = issue ? addr_q : '0;
  assign bus.mem_wdata = issue ? wdata_q : '0;

  assign bus.ReadDataM = cpu_rd_q;
  assign bus.dma_rdata = dma_rd_q;

  // grant is decided combinationally in IDLE;
  // masked so it reads 0 while reset is held
  assign bus.dma_gnt  = reset & dma_win;
  assign bus.dma_done = (state_q == S_DONE)
                      & (owner_q == OWN_DMA);

  // pipeline advances only in the CPU's DONE cycle
  assign bus.StallM = cpu_req
    & ~((state_q == S_DONE) & (owner_q == OWN_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, corner sequences,
// randomized CPU/DMA traffic against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int LAT = 2;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  // memory macro model: read data valid LAT cycles after mem_en
  logic [31:0] mem_arr [logic [31:0]];
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;
  rd_t pend[$];
  int  cyc = 0;

  function automatic logic [31:0] mrd(logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we)
          mem_arr[bus.mem_addr] = bus.mem_wdata;
        else
          pend.push_back('{cyc + LAT, mrd(bus.mem_addr)});
      end
      @(posedge clk);
      #1;
      cyc++;
      while (pend.size() > 0 && pend[0].due < cyc)
        void'(pend.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        bus.mem_rdata = pend[0].data;
        void'(pend.pop_front());
      end else begin
        bus.mem_rdata = $urandom;
      end
    end
  end

  int n_en = 0, n_gnt = 0, n_done = 0;
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1)   n_en++;
    if (bus.dma_gnt === 1'b1)  n_gnt++;
    if (bus.dma_done === 1'b1) n_done++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = '0;
    bus.WriteDataM = '0;
    bus.dma_req    = 1'b0;
    bus.dma_we     = 1'b0;
    bus.dma_addr   = '0;
    bus.dma_wdata  = '0;
  endtask

  typedef struct {
    string       name;
    bit          rd, wr, dma, dwe;
    logic [31:0] addr, wdata;
    bit          pre;
    logic [31:0] mdata;
    int          exp_stall;
    bit          exp_we;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic run_one(vec_t v);
    int stall, en, gc, dc, nd;
    bit cbusy, cfin, gseen;
    logic        we_s;
    logic [31:0] addr_s, wdata_s;
    stall = 0; en = 0; gc = -100; dc = 0; nd = 0;
    we_s = 1'b0; addr_s = '0; wdata_s = '0;
    if (v.pre) mem_arr[v.addr] = v.mdata;
    cbusy = v.rd | v.wr;
    bus.MemReadM   = v.rd;
    bus.MemWriteM  = v.wr;
    bus.ALUResultM = v.addr;
    bus.WriteDataM = v.wdata;
    bus.dma_req    = v.dma;
    bus.dma_we     = v.dwe;
    bus.dma_addr   = v.addr;
    bus.dma_wdata  = v.wdata;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en++;
        we_s    = bus.mem_we;
        addr_s  = bus.mem_addr;
        wdata_s = bus.mem_wdata;
      end
      if (bus.StallM) stall++;
      gseen = bus.dma_gnt;
      if (gseen) gc = c;
      if (bus.dma_done) begin dc = c; nd++; end
      cfin = cbusy && !bus.StallM;
      tick();
      if (gseen) bus.dma_req = 1'b0;
      if (cfin) begin
        bus.MemReadM  = 1'b0;
        bus.MemWriteM = 1'b0;
        cbusy = 1'b0;
      end
    end
    chk({v.name, ".stall"}, stall, v.exp_stall);
    chk({v.name, ".en_pulses"}, en, 1);
    chk({v.name, ".mem_we"}, {31'b0, we_s}, {31'b0, v.exp_we});
    chk({v.name, ".mem_addr"}, addr_s, v.addr);
    if (v.exp_we)
      chk({v.name, ".mem_wdata"}, wdata_s, v.wdata);
    chk({v.name, ".dma_done"}, nd, {31'b0, v.dma});
    if (v.dma)
      chk({v.name, ".gnt_to_done"}, dc - gc, v.exp_lat);
    if (!v.exp_we)
      chk({v.name, ".rdata"},
          v.dma ? bus.dma_rdata : bus.ReadDataM, v.exp_rd);
    idle_in();
  endtask

  logic [31:0] cpu_ref[8];
  logic [31:0] dma_ref[8];
  int cpu_ops, dma_ops;
  int en0, gnt0, done0;
  bit seq[10];
  int k, bad, g;

  initial begin : main
    vecs = '{
      '{"cpu_rd", 1,0,0,0, 32'h1000, 32'h0, 1, 32'hDEADBEEF,
        4, 0, 0, 32'hDEADBEEF},
      '{"cpu_wr", 0,1,0,0, 32'h1010, 32'h20, 0, 32'h0,
        2, 1, 0, 32'h0},
      '{"dma_rd", 0,0,1,0, 32'h2000, 32'h0, 1, 32'h12345678,
        0, 0, 4, 32'h12345678},
      '{"rd_wr_both", 1,1,0,0, 32'h1020, 32'hA5A5, 0, 32'h0,
        2, 1, 0, 32'h0},
      '{"dma_wr", 0,0,1,1, 32'h2004, 32'hCAFE, 0, 32'h0,
        0, 1, 2, 32'h0},
      '{"cpu_rb", 1,0,0,0, 32'h1010, 32'h0, 0, 32'h0,
        4, 0, 0, 32'h20},
      '{"cpu_rb_dma", 1,0,0,0, 32'h2004, 32'h0, 0, 32'h0,
        4, 0, 0, 32'hCAFE},
      '{"dma_rb_cpu", 0,0,1,0, 32'h1020, 32'h0, 0, 32'h0,
        0, 0, 4, 32'hA5A5}
    };

    // reset state, with a DMA request already pending
    idle_in();
    bus.dma_req = 1'b1;
    @(negedge clk);
    chk("reset.ctrl",
        {27'b0, bus.mem_en, bus.mem_we, bus.dma_gnt,
         bus.dma_done, bus.StallM}, 32'h0);
    chk("reset.mem_addr", bus.mem_addr, 32'h0);
    chk("reset.mem_wdata", bus.mem_wdata, 32'h0);
    chk("reset.ReadDataM", bus.ReadDataM, 32'h0);
    chk("reset.dma_rdata", bus.dma_rdata, 32'h0);
    bus.dma_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    foreach (vecs[i]) run_one(vecs[i]);

    // starvation: CPU and DMA both request continuously
    mem_arr[32'h3000] = 32'h33;
    mem_arr[32'h4000] = 32'h44;
    bus.MemReadM   = 1'b1;
    bus.ALUResultM = 32'h3000;
    bus.dma_req    = 1'b1;
    bus.dma_we     = 1'b0;
    bus.dma_addr   = 32'h4000;
    k = 0;
    for (int c = 0; c < 200 && k < 10; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        seq[k] = (bus.mem_addr == 32'h4000);
        k++;
      end
      tick();
    end
    chk("starve.accesses", k, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve.grant%0d_is_dma", i),
          {31'b0, seq[i]},
          {31'b0, (i % (LIM + 1)) == LIM});
    idle_in();
    repeat (8) tick();

    // reset during the WAIT of a DMA read
    bus.dma_req  = 1'b1;
    bus.dma_addr = 32'h2000;
    g = 0;
    for (int c = 0; c < 10 && g == 0; c++) begin
      @(negedge clk);
      g = bus.dma_gnt ? 1 : 0;
      tick();
    end
    chk("abort.gnt", g, 1);
    bus.dma_req = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("abort.ctrl",
        {27'b0, bus.mem_en, bus.mem_we, bus.dma_gnt,
         bus.dma_done, bus.StallM}, 32'h0);
    chk("abort.dma_rdata", bus.dma_rdata, 32'h0);
    chk("abort.ReadDataM", bus.ReadDataM, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("abort.idle", {30'b0, dut.state_q}, {30'b0, S_IDLE});
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.mem_en || bus.dma_done) bad++;
      @(negedge clk);
    end
    chk("abort.no_retry", bad, 0);
    tick();
    run_one(vecs[0]);

    // randomized traffic, disjoint CPU/DMA address windows
    for (int i = 0; i < 8; i++) begin
      cpu_ref[i] = $urandom;
      dma_ref[i] = $urandom;
      mem_arr[32'h100 + 4 * i] = cpu_ref[i];
      mem_arr[32'h800 + 4 * i] = dma_ref[i];
    end
    cpu_ops = 0; dma_ops = 0;
    en0 = n_en; gnt0 = n_gnt; done0 = n_done;
    fork
      begin : cpu_p
        int op, idx, got;
        logic [31:0] d;
        for (int i = 0; i < 60; i++) begin
          op  = $urandom_range(0, 3);
          idx = $urandom_range(0, 7);
          d   = $urandom;
          if (op == 0) begin
            tick();
            continue;
          end
          bus.MemReadM   = (op != 2);
          bus.MemWriteM  = (op >= 2);
          bus.ALUResultM = 32'h100 + 4 * idx;
          bus.WriteDataM = d;
          cpu_ops++;
          got = 0;
          for (int c = 0; c < 60 && got == 0; c++) begin
            @(negedge clk);
            if (!bus.StallM) begin
              got = 1;
              if (!bus.MemWriteM)
                chk("rnd.cpu_rd", bus.ReadDataM, cpu_ref[idx]);
              else
                cpu_ref[idx] = d;
            end
            tick();
          end
          chk("rnd.cpu_complete", got, 1);
          bus.MemReadM  = 1'b0;
          bus.MemWriteM = 1'b0;
        end
      end
      begin : dma_p
        int idx, got, wins;
        bit we;
        logic [31:0] d;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          idx = $urandom_range(0, 7);
          we  = 1'($urandom_range(0, 1));
          d   = $urandom;
          bus.dma_req   = 1'b1;
          bus.dma_we    = we;
          bus.dma_addr  = 32'h800 + 4 * idx;
          bus.dma_wdata = d;
          dma_ops++;
          got = 0; wins = 0;
          for (int c = 0; c < 100 && got == 0; c++) begin
            @(negedge clk);
            if (bus.dma_gnt) got = 1;
            else if ((bus.MemReadM | bus.MemWriteM)
                     && !bus.StallM) wins++;
            tick();
          end
          chk("rnd.dma_gnt", got, 1);
          chk("rnd.starve_bound",
              {31'b0, wins <= LIM + 1}, 32'h1);
          bus.dma_req = 1'b0;
          got = 0;
          for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (bus.dma_done) begin
              got = 1;
              if (!we)
                chk("rnd.dma_rd", bus.dma_rdata, dma_ref[idx]);
              else
                dma_ref[idx] = d;
            end
            tick();
          end
          chk("rnd.dma_done", got, 1);
        end
      end
    join
    idle_in();
    repeat (8) tick();
    chk("rnd.mem_en_total", n_en - en0, cpu_ops + dma_ops);
    chk("rnd.gnt_total", n_gnt - gnt0, dma_ops);
    chk("rnd.done_total", n_done - done0, dma_ops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
